// File: rtl/pulse_checker_pkg.sv
// Shared definitions for the BIST pulse-train checker: default train shape,
// error-vector bit positions, FSM state encoding and a saturating increment.
package pulse_checker_pkg;

  // Default train shape, matched to the controller's N_MAX/M_MAX settings
  localparam int unsigned DEF_HIGH_LEN  = 8;
  localparam int unsigned DEF_LOW_LEN   = 1;
  localparam int unsigned DEF_PULSE_CNT = 10;

  // Bit positions inside the sticky error vector
  localparam int unsigned ERR_WIDTH = 0;
  localparam int unsigned ERR_GAP   = 1;
  localparam int unsigned ERR_COUNT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 4-bit increment that sticks at 15 instead of wrapping
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/pulse_checker_sat_counter.sv
// 4-bit saturating counter with synchronous clear. clr together with en
// loads 1, so a phase counter can restart on the first sample of a phase.
module sat_counter_4b
  import pulse_checker_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] count
);

  // Count register: reset, clear/load-1, or saturating increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= en ? 4'd1 : 4'd0;
    end else if (en) begin
      count <= sat_inc4(count);
    end
  end

endmodule

// File: rtl/pulse_checker.sv
// Monitor for the BIST pulse controller: checks PULSE_CNT high pulses of
// HIGH_LEN cycles separated by LOW_LEN-cycle gaps, closed by bist_end, and
// reports a registered pass/fail verdict with a sticky error vector.
module pulse_checker
  import pulse_checker_pkg::*;
#(
  parameter int unsigned HIGH_LEN  = DEF_HIGH_LEN,
  parameter int unsigned LOW_LEN   = DEF_LOW_LEN,
  parameter int unsigned PULSE_CNT = DEF_PULSE_CNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  input  logic       running,
  input  logic       bist_end,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [2:0] err,
  output logic [3:0] pulse_cnt
);

  localparam logic [3:0] HIGH_LEN4  = 4'(HIGH_LEN);
  localparam logic [3:0] LOW_LEN4   = 4'(LOW_LEN);
  localparam logic [3:0] PULSE_CNT4 = 4'(PULSE_CNT);

  state_t     state, state_next;
  logic [3:0] hi_len, lo_len, cnt_next;
  logic       hi_clr, hi_en, lo_clr, lo_en, cnt_clr, cnt_en;
  logic       go_done, restart, pass_next;
  logic [2:0] err_set, err_acc, err_next;

  sat_counter_4b u_hi_len (
    .clk   (clk),
    .reset (reset),
    .clr   (hi_clr),
    .en    (hi_en),
    .count (hi_len)
  );

  sat_counter_4b u_lo_len (
    .clk   (clk),
    .reset (reset),
    .clr   (lo_clr),
    .en    (lo_en),
    .count (lo_len)
  );

  sat_counter_4b u_pulse_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (pulse_cnt)
  );

  // Next-state decode, counter controls and error accumulation for this sample.
  // The verdict uses the post-update count and errors so that done/pass
  // appear exactly one cycle after the closing sample.
  always_comb begin
    state_next = state;
    hi_clr     = 1'b0;
    hi_en      = 1'b0;
    lo_clr     = 1'b0;
    lo_en      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    go_done    = 1'b0;
    restart    = 1'b0;
    err_set    = '0;

    case (state)
      IDLE, DONE: begin
        if (running && pulse_in) begin
          state_next = HIGH;
          hi_clr     = 1'b1;
          hi_en      = 1'b1;
          cnt_clr    = 1'b1;
          restart    = 1'b1;
        end else if (bist_end && state == IDLE) begin
          state_next         = DONE;
          go_done            = 1'b1;
          err_set[ERR_COUNT] = 1'b1;
        end
      end
      HIGH: begin
        if (!pulse_in) begin
          cnt_en = 1'b1;
          if (hi_len != HIGH_LEN4) err_set[ERR_WIDTH] = 1'b1;
          if (bist_end) begin
            state_next = DONE;
            go_done    = 1'b1;
          end else if (running) begin
            state_next = LOW;
            lo_clr     = 1'b1;
            lo_en      = 1'b1;
          end else begin
            state_next         = DONE;
            go_done            = 1'b1;
            err_set[ERR_COUNT] = 1'b1;
          end
        end else if (running) begin
          hi_en = 1'b1;
        end else begin
          state_next         = DONE;
          go_done            = 1'b1;
          err_set[ERR_COUNT] = 1'b1;
        end
      end
      LOW: begin
        if (pulse_in) begin
          if (lo_len != LOW_LEN4) err_set[ERR_GAP] = 1'b1;
          state_next = HIGH;
          hi_clr     = 1'b1;
          hi_en      = 1'b1;
        end else begin
          lo_en = 1'b1;
          if (bist_end || !running) begin
            state_next         = DONE;
            go_done            = 1'b1;
            err_set[ERR_COUNT] = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    cnt_next = cnt_en ? sat_inc4(pulse_cnt) : pulse_cnt;
    err_acc  = restart ? '0 : (err | err_set);
    err_next = err_acc;
    if (go_done && (cnt_next != PULSE_CNT4)) err_next[ERR_COUNT] = 1'b1;
    pass_next = (err_next == '0);
  end

  // State register and registered verdict outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
      err   <= '0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (restart) begin
        done <= 1'b0;
        pass <= 1'b0;
        fail <= 1'b0;
      end else if (go_done) begin
        done <= 1'b1;
        pass <= pass_next;
        fail <= ~pass_next;
      end
    end
  end

endmodule

// File: tb/tb_pulse_checker.sv
// Bench for pulse_checker: drives pulse trains described by per-pulse high
// lengths and per-gap low lengths, and predicts the verdict from the train
// description (width/gap/count rules) rather than from a cycle model.
module tb_pulse_checker;

  localparam int unsigned HL = 8;
  localparam int unsigned LL = 1;
  localparam int unsigned PC = 10;

  logic       clk = 1'b0;
  logic       reset, pulse_in, running, bist_end;
  logic       done, pass, fail;
  logic [2:0] err;
  logic [3:0] pulse_cnt;

  int checks = 0;
  int errors = 0;

  int hi_arr [16];
  int gap_arr[16];

  logic [9:0] expv, obs;

  pulse_checker #(
    .HIGH_LEN  (HL),
    .LOW_LEN   (LL),
    .PULSE_CNT (PC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .running   (running),
    .bist_end  (bist_end),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .err       (err),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] observed();
    return {done, pass, fail, err, pulse_cnt};
  endfunction

  // Expected {done,pass,fail,err,pulse_cnt} for a train of n_closed completed
  // pulses, optionally followed by one aborted pulse.
  function automatic logic [9:0] model(input int n_closed, input bit aborted);
    logic [2:0] e;
    int         started;
    int         cnt;
    logic       p;
    e       = '0;
    started = aborted ? n_closed + 1 : n_closed;
    for (int i = 0; i < n_closed; i++)
      if (hi_arr[i] != int'(HL)) e[0] = 1'b1;
    for (int i = 1; i < started; i++)
      if (gap_arr[i-1] != int'(LL)) e[1] = 1'b1;
    if (aborted || n_closed != int'(PC)) e[2] = 1'b1;
    cnt = (n_closed > 15) ? 15 : n_closed;
    p   = (e == 3'b000);
    return {1'b1, p, ~p, e, 4'(cnt)};
  endfunction

  task automatic set_nominal();
    for (int i = 0; i < 16; i++) begin
      hi_arr[i]  = HL;
      gap_arr[i] = LL;
    end
  endtask

  // Drive n pulses from hi_arr/gap_arr. If cut_at >= 0, pulse cut_at is cut
  // after cut_hi high cycles, by dropping running (cut_reset=0) or by a
  // one-cycle reset (cut_reset=1). check_restart verifies the verdict clears
  // one cycle after the train starts.
  task automatic drive_train(input int n, input int cut_at, input int cut_hi,
                             input bit cut_reset, input bit check_restart);
    int hcount;
    bist_end = 1'b0;
    for (int p = 0; p < n; p++) begin
      hcount = (p == cut_at) ? cut_hi : hi_arr[p];
      for (int c = 0; c < hcount; c++) begin
        running  = 1'b1;
        pulse_in = 1'b1;
        step();
        if (check_restart && p == 0 && c == 0) begin
          checks++;
          if ({done, pass, fail, pulse_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL restart_clear: got done/pass/fail/cnt=%b expected %b",
                     {done, pass, fail, pulse_cnt}, 7'b0);
          end
        end
      end
      if (p == cut_at) begin
        if (cut_reset) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
        end else begin
          running  = 1'b0;
          pulse_in = 1'b1;
          step();
        end
        running  = 1'b0;
        pulse_in = 1'b0;
        return;
      end
      if (p < n - 1) begin
        for (int c = 0; c < gap_arr[p]; c++) begin
          running  = 1'b1;
          pulse_in = 1'b0;
          step();
        end
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_early: got done=%b expected 0 before closing edge", done);
        end
        running  = 1'b1;
        pulse_in = 1'b0;
        bist_end = 1'b1;
        step();
        bist_end = 1'b0;
        running  = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pulse_in = 1'b0; running = 1'b0; bist_end = 1'b0;
    step();
    step();
    reset = 1'b0;
    obs = observed();
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, 10'b0);
    end
    // bist_end while idle reports a failed run with nothing counted
    bist_end = 1'b1;
    step();
    bist_end = 1'b0;
    obs  = observed();
    expv = {1'b1, 1'b0, 1'b1, 3'b100, 4'd0};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL idle_bist_end: got %b expected %b", obs, expv);
    end
  endtask

  task automatic test_golden();
    set_nominal();
    drive_train(PC, -1, 0, 1'b0, 1'b1);
    obs  = observed();
    expv = {1'b1, 1'b1, 1'b0, 3'b000, 4'(PC)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL golden: got %b expected %b", obs, expv);
    end
    // repeated bist_end in DONE must not disturb the verdict
    bist_end = 1'b1;
    step();
    bist_end = 1'b0;
    step();
    obs = observed();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL bist_end_repeat: got %b expected %b", obs, expv);
    end
  endtask

  task automatic test_width_error();
    set_nominal();
    hi_arr[3] = HL - 1;
    drive_train(PC, -1, 0, 1'b0, 1'b0);
    obs  = observed();
    expv = {1'b1, 1'b0, 1'b1, 3'b001, 4'(PC)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL width_error: got %b expected %b", obs, expv);
    end
  endtask

  task automatic test_gap_and_count();
    set_nominal();
    gap_arr[2] = LL + 1;
    drive_train(PC, -1, 0, 1'b0, 1'b0);
    obs  = observed();
    expv = {1'b1, 1'b0, 1'b1, 3'b010, 4'(PC)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL gap_error: got %b expected %b", obs, expv);
    end
    set_nominal();
    drive_train(PC - 1, -1, 0, 1'b0, 1'b0);
    obs  = observed();
    expv = {1'b1, 1'b0, 1'b1, 3'b100, 4'(PC - 1)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL short_count: got %b expected %b", obs, expv);
    end
  endtask

  task automatic test_abort();
    set_nominal();
    drive_train(PC, 4, 3, 1'b0, 1'b0);
    obs  = observed();
    expv = {1'b1, 1'b0, 1'b1, 3'b100, 4'd4};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL abort_high: got %b expected %b", obs, expv);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      set_nominal();
      drive_train(PC, -1, 0, 1'b0, 1'b1);
      obs  = observed();
      expv = {1'b1, 1'b1, 1'b0, 3'b000, 4'(PC)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL back_to_back run %0d: got %b expected %b", r, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    set_nominal();
    drive_train(PC, 5, 3, 1'b1, 1'b0);
    obs = observed();
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got %b expected %b", obs, 10'b0);
    end
    step();
    drive_train(PC, -1, 0, 1'b0, 1'b0);
    obs  = observed();
    expv = {1'b1, 1'b1, 1'b0, 3'b000, 4'(PC)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL after_reset_golden: got %b expected %b", obs, expv);
    end
  endtask

  task automatic test_random();
    int n, cut, cut_hi;
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(PC + 1, PC - 2);
      for (int i = 0; i < 16; i++) begin
        hi_arr[i]  = ($urandom_range(0, 4) == 0) ? ($urandom_range(0, 1) ? HL + 1 : HL - 1) : HL;
        gap_arr[i] = ($urandom_range(0, 4) == 0) ? LL + 1 : LL;
      end
      cut    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      cut_hi = $urandom_range(1, HL);
      drive_train(n, cut, cut_hi, 1'b0, 1'b1);
      obs  = observed();
      expv = (cut >= 0) ? model(cut, 1'b1) : model(n, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random run %0d (n=%0d cut=%0d): got %b expected %b",
                 r, n, cut, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_width_error();
    test_gap_and_count();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
